// File: rtl/npc_pkg.sv
// npc_pkg: shared constants for the NPC sequencer.
//   - 3-bit state encoding (ST_FETCH .. ST_HALT) and the matching enum type
//   - default reset PC
//   - performance counter width
package npc_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_IWAIT  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_MWAIT  = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_FETCH  = ST_FETCH,
        S_IWAIT  = ST_IWAIT,
        S_DECODE = ST_DECODE,
        S_MEM    = ST_MEM,
        S_MWAIT  = ST_MWAIT,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_e;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
    localparam int          CNT_W        = 64;

endpackage

// File: rtl/npc_perf_cnt.sv
// npc_perf_cnt: cycle and retired-instruction counters.
//   clk, rst     : core clock, synchronous active-high reset
//   in_wb        : sequencer is in its writeback cycle (one retire)
//   halted       : core stopped; both counters freeze
//   cycle_cnt    : non-halted cycles since reset, wraps mod 2^CNT_W
//   instret_cnt  : retired instructions since reset, wraps mod 2^CNT_W
module npc_perf_cnt
    import npc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_wb,
    input  logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (!halted) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (in_wb) instret_cnt_d = instret_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle sequencer for the NPC single-issue core.
// Owns PC and instruction register; steps each instruction through
// FETCH -> IWAIT -> DECODE -> [MEM -> [MWAIT]] -> WB, or into HALT.
// Ports:
//   clk, rst                        : core clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr : fetch request handshake (addr = pc)
//   imem_rsp_valid, imem_rsp_data   : returned instruction word
//   inst                            : instruction register, feeds the decoder
//   dec_is_load/store/ebreak/illegal: decoder flags for inst (used in DECODE)
//   dmem_req_valid/ready            : load/store request handshake
//   dmem_rsp_valid                  : load data returned
//   next_pc                         : EXU-resolved next PC, committed in WB
//   pc, rf_wen, halted, halt_illegal: architectural state / status
// Optional: define NPC_PERF_CNT_EN to add 64-bit cycle_cnt / instret_cnt.
module npc_ctrl
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_ebreak,
    input  logic        dec_illegal,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        rf_wen,
    output logic        halted,
    output logic        halt_illegal
`ifdef NPC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        is_store_q, is_store_d;
    logic        imem_req_valid_q, imem_req_valid_d;
    logic        dmem_req_valid_q, dmem_req_valid_d;
    logic        rf_wen_q, rf_wen_d;
    logic        halted_q, halted_d;
    logic        halt_illegal_q, halt_illegal_d;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        is_store_d     = is_store_q;
        halt_illegal_d = halt_illegal_q;
        unique case (state_q)
            S_FETCH:  if (imem_req_ready) state_d = S_IWAIT;
            S_IWAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                is_store_d = dec_is_store;
                if (dec_illegal) begin
                    state_d        = S_HALT;
                    halt_illegal_d = 1'b1;
                end else if (dec_is_ebreak) begin
                    state_d = S_HALT;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM:    if (dmem_req_ready) state_d = is_store_q ? S_WB : S_MWAIT;
            S_MWAIT:  if (dmem_rsp_valid) state_d = S_WB;
            S_WB: begin
                pc_d    = next_pc;
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        // Moore outputs are registered by decoding the next state, so each
        // one is valid for exactly the cycles spent in its state.
        imem_req_valid_d = (state_d == S_FETCH);
        dmem_req_valid_d = (state_d == S_MEM);
        rf_wen_d         = (state_d == S_WB) && !is_store_d;
        halted_d         = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_PC;
            inst_q           <= '0;
            is_store_q       <= 1'b0;
            imem_req_valid_q <= 1'b1;
            dmem_req_valid_q <= 1'b0;
            rf_wen_q         <= 1'b0;
            halted_q         <= 1'b0;
            halt_illegal_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inst_q           <= inst_d;
            is_store_q       <= is_store_d;
            imem_req_valid_q <= imem_req_valid_d;
            dmem_req_valid_q <= dmem_req_valid_d;
            rf_wen_q         <= rf_wen_d;
            halted_q         <= halted_d;
            halt_illegal_q   <= halt_illegal_d;
        end
    end

    assign imem_req_valid = imem_req_valid_q;
    assign imem_addr      = pc_q;
    assign inst           = inst_q;
    assign dmem_req_valid = dmem_req_valid_q;
    assign pc             = pc_q;
    assign rf_wen         = rf_wen_q;
    assign halted         = halted_q;
    assign halt_illegal   = halt_illegal_q;

`ifdef NPC_PERF_CNT_EN
    logic in_wb;
    assign in_wb = (state_q == S_WB);

    npc_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .in_wb       (in_wb),
        .halted      (halted_q),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: directed, table-driven bench for npc_ctrl. The bench acts as
// decoder, EXU and both memories. Each table row is one instruction with its
// handshake delays and hand-computed latency / write-strobe expectations.
module tb_npc_ctrl;
    import npc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data, inst, next_pc, pc;
    logic        dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal;
    logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
    logic        rf_wen, halted, halt_illegal;
`ifdef NPC_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    npc_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .dec_is_load    (dec_is_load),
        .dec_is_store   (dec_is_store),
        .dec_is_ebreak  (dec_is_ebreak),
        .dec_illegal    (dec_illegal),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_rsp_valid (dmem_rsp_valid),
        .next_pc        (next_pc),
        .pc             (pc),
        .rf_wen         (rf_wen),
        .halted         (halted),
        .halt_illegal   (halt_illegal)
`ifdef NPC_PERF_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
`endif
    );

    typedef enum {K_ALU, K_LOAD, K_STORE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] word;
        logic [31:0] npc;
        int          ird;     // cycles imem_req_ready held low
        int          irsp;    // extra cycles after acceptance before rsp
        int          drd;     // cycles dmem_req_ready held low
        int          drsp;    // extra cycles after dmem acceptance before rsp
        int          exp_lat; // cycles from fetch start to next fetch
        int          exp_wen; // number of rf_wen pulses
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        dec_is_load = 0; dec_is_store = 0; dec_is_ebreak = 0; dec_illegal = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; next_pc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // Runs one instruction starting in a FETCH cycle; ends in the next FETCH.
    task automatic run_vec(input int idx, input vec_t v, input logic [31:0] pc0);
        int c = 1, iacc = 0, dacc = 0, dv = 0, dm_n = 0, wen_n = 0, wen_c = 0, lat = 0;
        bit hold_ok = 1, done = 0;
        logic [63:0] cyc0, ret0;
        cyc0 = '0; ret0 = '0;
`ifdef NPC_PERF_CNT_EN
        cyc0 = cycle_cnt; ret0 = instret_cnt;
`endif
        dec_is_load   = (v.kind == K_LOAD);
        dec_is_store  = (v.kind == K_STORE);
        dec_is_ebreak = 0;
        dec_illegal   = 0;
        imem_rsp_data = v.word;
        next_pc       = v.npc;
        while (!done && c <= 60) begin
            if (iacc != 0 && c > iacc && imem_req_valid) begin
                done = 1;
                lat  = c - 1;
            end else begin
                imem_req_ready = (iacc == 0) && (c > v.ird);
                imem_rsp_valid = (iacc != 0) && (c == iacc + 1 + v.irsp);
                dmem_req_ready = dmem_req_valid && (dv >= v.drd);
                dmem_rsp_valid = (v.kind == K_LOAD) && (dacc != 0) && (c == dacc + 1 + v.drsp);
                if (iacc == 0 && !(imem_req_valid && imem_addr == pc0)) hold_ok = 0;
                if (imem_req_valid && imem_req_ready) iacc = c;
                if (dmem_req_valid) begin
                    dm_n++;
                    if (dmem_req_ready) dacc = c;
                    dv++;
                end
                if (rf_wen) begin
                    wen_n++;
                    wen_c = c;
                end
                step();
                c++;
            end
        end
        idle_inputs();
        chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_hold", idx), 64'(hold_ok), 64'd1);
        chk($sformatf("v%0d_fetch_acc_cycle", idx), 64'(iacc), 64'(v.ird + 1));
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d_wen_count", idx), 64'(wen_n), 64'(v.exp_wen));
        chk($sformatf("v%0d_wen_cycle", idx), 64'(wen_c), 64'(v.exp_wen != 0 ? v.exp_lat : 0));
        chk($sformatf("v%0d_dmem_cycles", idx), 64'(dm_n), 64'(v.kind == K_ALU ? 0 : 1 + v.drd));
        chk($sformatf("v%0d_pc", idx), 64'(pc), 64'(v.npc));
        chk($sformatf("v%0d_inst", idx), 64'(inst), 64'(v.word));
`ifdef NPC_PERF_CNT_EN
        chk($sformatf("v%0d_cycle_delta", idx), cycle_cnt - cyc0, 64'(v.exp_lat));
        chk($sformatf("v%0d_instret_delta", idx), instret_cnt - ret0, 64'd1);
`endif
    endtask

    // FETCH (with a same-cycle junk response) -> IWAIT -> DECODE with given flags.
    task automatic fetch_decode(input logic [31:0] word, input logic ld, input logic eb, input logic ill);
        imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'hdead_beef;
        step();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = word;
        step();
        imem_rsp_valid = 0; imem_rsp_data = '0;
        dec_is_load = ld; dec_is_ebreak = eb; dec_illegal = ill;
        step();
        dec_is_load = 0; dec_is_ebreak = 0; dec_illegal = 0;
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] exp_pc;
        int iv, dv, wn;
        bit frozen;
        logic [63:0] cyc_h;

        vecs[0] = '{K_ALU,   32'h0010_0093, 32'h8000_0004, 0, 0, 0, 0,  4, 1};
        vecs[1] = '{K_ALU,   32'h0020_8113, 32'h8000_0008, 3, 0, 0, 0,  7, 1};
        vecs[2] = '{K_LOAD,  32'h0000_a183, 32'h8000_000c, 0, 0, 2, 3, 11, 1};
        vecs[3] = '{K_STORE, 32'h0030_a223, 32'h8000_0010, 0, 0, 0, 0,  5, 0};
        vecs[4] = '{K_ALU,   32'h0000_006f, 32'h8000_0100, 0, 2, 0, 0,  6, 1};
        vecs[5] = '{K_STORE, 32'h0030_a423, 32'h8000_0104, 0, 1, 1, 0,  7, 0};
        vecs[6] = '{K_LOAD,  32'h0040_a203, 32'h8000_0108, 0, 0, 0, 0,  6, 1};

        do_reset();
        chk("rst_imem_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rst_imem_addr", 64'(imem_addr), 64'(RST_PC));
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_halt_illegal", 64'(halt_illegal), 64'd0);
        chk("rst_dmem_req_valid", 64'(dmem_req_valid), 64'd0);
`ifdef NPC_PERF_CNT_EN
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instret_cnt", instret_cnt, 64'd0);
`endif

        exp_pc = RST_PC;
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i], exp_pc);
            exp_pc = vecs[i].npc;
        end

        // ebreak: halts cleanly and stays halted under any stimulus.
        fetch_decode(32'h0010_0073, 1'b0, 1'b1, 1'b0);
        chk("ebreak_halted", 64'(halted), 64'd1);
        chk("ebreak_halt_illegal", 64'(halt_illegal), 64'd0);
        chk("ebreak_inst", 64'(inst), 64'h0010_0073);
        cyc_h = '0;
`ifdef NPC_PERF_CNT_EN
        cyc_h = cycle_cnt;
`endif
        iv = 0; dv = 0; wn = 0; frozen = 1;
        imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678;
        dmem_req_ready = 1; dmem_rsp_valid = 1; next_pc = 32'h0bad_0000;
        for (int k = 0; k < 20; k++) begin
            step();
            if (imem_req_valid) iv++;
            if (dmem_req_valid) dv++;
            if (rf_wen) wn++;
            if (pc != 32'h8000_0108 || inst != 32'h0010_0073 || !halted) frozen = 0;
        end
        idle_inputs();
        chk("halt_no_imem_req", 64'(iv), 64'd0);
        chk("halt_no_dmem_req", 64'(dv), 64'd0);
        chk("halt_no_rf_wen", 64'(wn), 64'd0);
        chk("halt_frozen", 64'(frozen), 64'd1);
`ifdef NPC_PERF_CNT_EN
        chk("halt_cycle_frozen", cycle_cnt, cyc_h);
`endif

        // Illegal beats ebreak in priority and flags the halt cause.
        do_reset();
        chk("post_halt_rst_halted", 64'(halted), 64'd0);
        chk("post_halt_rst_pc", 64'(pc), 64'(RST_PC));
        fetch_decode(32'hffff_ffff, 1'b0, 1'b1, 1'b1);
        chk("illegal_halted", 64'(halted), 64'd1);
        chk("illegal_halt_illegal", 64'(halt_illegal), 64'd1);

        // Reset while a load waits in MWAIT; the late response must be dropped.
        do_reset();
        chk("post_ill_rst_halt_illegal", 64'(halt_illegal), 64'd0);
        fetch_decode(32'h0000_a183, 1'b1, 1'b0, 1'b0);
        chk("mw_dmem_req", 64'(dmem_req_valid), 64'd1);
        dmem_req_ready = 1;
        step();
        dmem_req_ready = 0;
        chk("mw_in_mwait", 64'(dmem_req_valid | rf_wen | imem_req_valid), 64'd0);
        rst = 1;
        step();
        rst = 0;
        dmem_rsp_valid = 1; imem_rsp_valid = 1; imem_rsp_data = 32'hcafe_f00d;
        chk("mw_rst_fetch", 64'(imem_req_valid), 64'd1);
        chk("mw_rst_pc", 64'(pc), 64'(RST_PC));
`ifdef NPC_PERF_CNT_EN
        chk("mw_rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("mw_rst_instret_cnt", instret_cnt, 64'd0);
`endif
        wn = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            dmem_rsp_valid = 0; imem_rsp_valid = 0;
            if (rf_wen) wn++;
        end
        chk("mw_stale_no_wen", 64'(wn), 64'd0);
        chk("mw_still_fetch", 64'(imem_req_valid), 64'd1);
        chk("mw_inst_clear", 64'(inst), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
